branch_predict_nway: RTL and testbench

- Parametrised successor branch predictor for an N-wide fetch front end.
- Contents: direct-mapped BTB with per-entry 2-bit saturating counters, plus a circular return-address stack (RAS) with speculative and committed pointers.
- Sits between IF and the fetch PC mux. Takes ex resolution for training and for RAS recovery.
- Prediction is registered: one cycle after ifVld.

---
 rtl/branch_predict_nway_if.sv | 34 +++
 rtl/branch_predict_nway.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_branch_predict_nway.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_nway_if.sv
// Signal bundle for branch_predict_nway: fetch request, execute resolution
// and the registered prediction returned to the fetch PC mux.
interface branch_predict_nway_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LANE_WIDTH = 1
);
    // Handshake: there is no backpressure anywhere. ifVld and exVld are
    // single-cycle strobes that are always accepted; exWrong squashes the
    // same-cycle request. pdVld qualifies pdPC/pdBranch/pdLane and rises
    // exactly one cycle after an accepted ifVld; the pd* payload holds its
    // last value whenever pdVld is low.
    logic                  ifVld;
    logic [ADDR_WIDTH-1:0] ifPC;
    logic                  exVld;
    logic [ADDR_WIDTH-1:0] exPC;
    logic [ADDR_WIDTH-1:0] exPCTar;
    logic [1:0]            exType;
    logic                  exBranch;
    logic                  exWrong;
    logic                  pdVld;
    logic [ADDR_WIDTH-1:0] pdPC;
    logic                  pdBranch;
    logic [LANE_WIDTH-1:0] pdLane;

    modport master (
        output ifVld, ifPC, exVld, exPC, exPCTar, exType, exBranch, exWrong,
        input  pdVld, pdPC, pdBranch, pdLane
    );

    modport slave (
        input  ifVld, ifPC, exVld, exPC, exPCTar, exType, exBranch, exWrong,
        output pdVld, pdPC, pdBranch, pdLane
    );
endinterface

// File: rtl/branch_predict_nway.sv
// N-wide successor branch predictor: direct-mapped BTB with 2-bit
// saturating counters plus a circular return-address stack carrying a
// speculative and a committed pointer/count pair.
// Optional feature macro: BP_GSHARE_EN moves the counters into a pattern
// history table indexed by (BTB index XOR global history).
module branch_predict_nway #(
    parameter int ADDR_WIDTH  = 32,
    parameter int FETCH_WIDTH = 2,
    parameter int BTB_DEPTH   = 6,
    parameter int TAG_WIDTH   = 10,
    parameter int RAS_DEPTH   = 3,
    parameter int GHR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predict_nway_if.slave  bp
);
    localparam int LANE_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam int BTB_ENTRIES = 1 << BTB_DEPTH;
    localparam int RAS_ENTRIES = 1 << RAS_DEPTH;
    localparam int CNT_W       = RAS_DEPTH + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BTB_DEPTH-1:0]  idx_t;
    typedef logic [RAS_DEPTH-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam logic [1:0] TYPE_COND = 2'b00;
    localparam logic [1:0] TYPE_CALL = 2'b10;
    localparam logic [1:0] TYPE_RET  = 2'b11;
    localparam cnt_t       CNT_FULL  = cnt_t'(RAS_ENTRIES);

    // Reject parameter sets the indexing below cannot represent.
    if (FETCH_WIDTH < 1 || FETCH_WIDTH > 8 || (FETCH_WIDTH & (FETCH_WIDTH - 1)) != 0 ||
        GHR_WIDTH < 2 || (BTB_DEPTH + 2 + TAG_WIDTH) > ADDR_WIDTH) begin : g_param_check
        $error("branch_predict_nway: unsupported parameter set");
    end

    // ------------------------------------------------------------------
    // Storage. ctr_q is the per-entry BTB counter in the default build and
    // the pattern history table when BP_GSHARE_EN is defined; only the
    // index used to reach it differs (ghr_fold is zero without gshare).
    // ------------------------------------------------------------------
    logic                 btb_vld_q  [BTB_ENTRIES];
    logic [TAG_WIDTH-1:0] btb_tag_q  [BTB_ENTRIES];
    addr_t                btb_tgt_q  [BTB_ENTRIES];
    logic [1:0]           btb_type_q [BTB_ENTRIES];
    logic [1:0]           ctr_q      [BTB_ENTRIES];
    addr_t                ras_q      [RAS_ENTRIES];

    ptr_t  spec_ptr_q,   spec_ptr_d;
    cnt_t  spec_cnt_q,   spec_cnt_d;
    ptr_t  commit_ptr_q, commit_ptr_d;
    cnt_t  commit_cnt_q, commit_cnt_d;

    logic              pd_vld_q,    pd_vld_d;
    addr_t             pd_pc_q,     pd_pc_d;
    logic              pd_branch_q, pd_branch_d;
    logic [LANE_W-1:0] pd_lane_q,   pd_lane_d;

    idx_t ghr_fold;

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

    // Shift resolved conditional outcomes into the global history.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.exVld && bp.exType == TYPE_COND) begin
            ghr_d = {ghr_q[GHR_WIDTH-2:0], bp.exBranch};
        end
    end

    // Global history register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_fold = idx_t'(ghr_q);
`else
    assign ghr_fold = '0;
`endif

    // ------------------------------------------------------------------
    // Per-lane lookup against the current (pre-training) table contents.
    // ------------------------------------------------------------------
    addr_t                  lane_pc  [FETCH_WIDTH];
    idx_t                   lane_idx [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] lane_taken;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
        logic [TAG_WIDTH-1:0] lane_tag;
        logic                 lane_hit;

        assign lane_pc[g]    = bp.ifPC + addr_t'(4 * g);
        assign lane_idx[g]   = lane_pc[g][BTB_DEPTH+1:2];
        assign lane_tag      = lane_pc[g][BTB_DEPTH+2 +: TAG_WIDTH];
        assign lane_hit      = btb_vld_q[lane_idx[g]] && (btb_tag_q[lane_idx[g]] == lane_tag);
        assign lane_taken[g] = lane_hit &&
                               ((btb_type_q[lane_idx[g]] != TYPE_COND) ||
                                ctr_q[lane_idx[g] ^ ghr_fold][1]);
    end

    logic              win_any;
    logic [LANE_W-1:0] win_lane;
    addr_t             win_pc;
    idx_t              win_idx;
    logic [1:0]        win_type;
    addr_t             pred_pc;

    // Pick the lowest taken lane: scan from the top so lower lanes overwrite.
    always_comb begin
        win_any  = 1'b0;
        win_lane = '0;
        win_pc   = '0;
        win_idx  = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (lane_taken[i]) begin
                win_any  = 1'b1;
                win_lane = LANE_W'(i);
                win_pc   = lane_pc[i];
                win_idx  = lane_idx[i];
            end
        end
        win_type = btb_type_q[win_idx];
    end

    // Next fetch PC: RAS top for a return with a non-empty stack, BTB target
    // for any other taken lane, sequential packet otherwise.
    always_comb begin
        pred_pc = bp.ifPC + addr_t'(4 * FETCH_WIDTH);
        if (win_any) begin
            if (win_type == TYPE_RET && spec_cnt_q != '0) begin
                pred_pc = ras_q[spec_ptr_q - ptr_t'(1)];
            end else begin
                pred_pc = btb_tgt_q[win_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction.
    // ------------------------------------------------------------------
    logic pd_load;
    assign pd_load = bp.ifVld & ~bp.exWrong;

    // pdVld follows every cycle; the payload only moves on an accepted fetch.
    always_comb begin
        pd_vld_d    = pd_load;
        pd_pc_d     = pd_pc_q;
        pd_branch_d = pd_branch_q;
        pd_lane_d   = pd_lane_q;
        if (pd_load) begin
            pd_pc_d     = pred_pc;
            pd_branch_d = win_any;
            pd_lane_d   = win_any ? win_lane : '0;
        end
    end

    // ------------------------------------------------------------------
    // Return-address stack pointers. The speculative side moves with the
    // predictions being registered; the committed side moves with resolved
    // calls/returns, and a flush copies the committed side (including this
    // cycle's update) back into the speculative side.
    // ------------------------------------------------------------------
    logic  spec_we,     commit_we;
    addr_t spec_wdata,  commit_wdata;

    assign spec_wdata   = win_pc + addr_t'(4);
    assign commit_wdata = bp.exPC + addr_t'(4);

    // Speculative and committed pointer/count updates plus flush recovery.
    always_comb begin
        spec_ptr_d   = spec_ptr_q;
        spec_cnt_d   = spec_cnt_q;
        commit_ptr_d = commit_ptr_q;
        commit_cnt_d = commit_cnt_q;
        spec_we      = 1'b0;
        commit_we    = 1'b0;

        if (pd_load && win_any) begin
            if (win_type == TYPE_CALL) begin
                spec_we    = 1'b1;
                spec_ptr_d = spec_ptr_q + ptr_t'(1);
                if (spec_cnt_q != CNT_FULL) begin
                    spec_cnt_d = spec_cnt_q + cnt_t'(1);
                end
            end else if (win_type == TYPE_RET && spec_cnt_q != '0) begin
                spec_ptr_d = spec_ptr_q - ptr_t'(1);
                spec_cnt_d = spec_cnt_q - cnt_t'(1);
            end
        end

        if (bp.exVld) begin
            if (bp.exType == TYPE_CALL) begin
                commit_we    = 1'b1;
                commit_ptr_d = commit_ptr_q + ptr_t'(1);
                if (commit_cnt_q != CNT_FULL) begin
                    commit_cnt_d = commit_cnt_q + cnt_t'(1);
                end
            end else if (bp.exType == TYPE_RET && commit_cnt_q != '0) begin
                commit_ptr_d = commit_ptr_q - ptr_t'(1);
                commit_cnt_d = commit_cnt_q - cnt_t'(1);
            end
        end

        if (bp.exWrong) begin
            spec_ptr_d = commit_ptr_d;
            spec_cnt_d = commit_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // BTB / counter training from the execute stage.
    // ------------------------------------------------------------------
    idx_t                 ex_idx;
    idx_t                 ex_ctr_idx;
    logic [TAG_WIDTH-1:0] ex_tag;
    logic                 ex_hit;
    logic                 btb_we;
    logic [1:0]           ctr_old;
    logic [1:0]           ctr_wdata;

    assign ex_idx     = bp.exPC[BTB_DEPTH+1:2];
    assign ex_tag     = bp.exPC[BTB_DEPTH+2 +: TAG_WIDTH];
    assign ex_ctr_idx = ex_idx ^ ghr_fold;
    assign ex_hit     = btb_vld_q[ex_idx] && (btb_tag_q[ex_idx] == ex_tag);
    assign ctr_old    = ctr_q[ex_ctr_idx];

    // Hits update in place with a saturating counter; taken misses allocate
    // weakly-taken; not-taken misses leave the table alone.
    always_comb begin
        btb_we    = bp.exVld && (ex_hit || bp.exBranch);
        ctr_wdata = 2'b10;
        if (ex_hit) begin
            ctr_wdata = ctr_old;
            if (bp.exBranch && ctr_old != 2'b11) begin
                ctr_wdata = ctr_old + 2'd1;
            end else if (!bp.exBranch && ctr_old != 2'b00) begin
                ctr_wdata = ctr_old - 2'd1;
            end
        end
    end

    // BTB and counter array; writes land at the clock edge, so a same-cycle
    // lookup of the trained index still sees the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_vld_q[i]  <= 1'b0;
                btb_tag_q[i]  <= '0;
                btb_tgt_q[i]  <= '0;
                btb_type_q[i] <= 2'b00;
                ctr_q[i]      <= 2'b01;
            end
        end else if (btb_we) begin
            btb_vld_q[ex_idx]  <= 1'b1;
            btb_tag_q[ex_idx]  <= ex_tag;
            btb_tgt_q[ex_idx]  <= bp.exPCTar;
            btb_type_q[ex_idx] <= bp.exType;
            ctr_q[ex_ctr_idx]  <= ctr_wdata;
        end
    end

    // RAS array; the commit write is issued last so it wins an address clash.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                ras_q[i] <= '0;
            end
        end else begin
            if (spec_we) begin
                ras_q[spec_ptr_q] <= spec_wdata;
            end
            if (commit_we) begin
                ras_q[commit_ptr_q] <= commit_wdata;
            end
        end
    end

    // Pointer, count and prediction output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spec_ptr_q   <= '0;
            spec_cnt_q   <= '0;
            commit_ptr_q <= '0;
            commit_cnt_q <= '0;
            pd_vld_q     <= 1'b0;
            pd_pc_q      <= '0;
            pd_branch_q  <= 1'b0;
            pd_lane_q    <= '0;
        end else begin
            spec_ptr_q   <= spec_ptr_d;
            spec_cnt_q   <= spec_cnt_d;
            commit_ptr_q <= commit_ptr_d;
            commit_cnt_q <= commit_cnt_d;
            pd_vld_q     <= pd_vld_d;
            pd_pc_q      <= pd_pc_d;
            pd_branch_q  <= pd_branch_d;
            pd_lane_q    <= pd_lane_d;
        end
    end

    assign bp.pdVld    = pd_vld_q;
    assign bp.pdPC     = pd_pc_q;
    assign bp.pdBranch = pd_branch_q;
    assign bp.pdLane   = pd_lane_q;

endmodule

// File: tb/tb_branch_predict_nway.sv
// Directed bench for branch_predict_nway (default build, FETCH_WIDTH=2,
// RAS_DEPTH=3). A behavioural model tracks the predictor from its rules and
// is compared against the DUT every cycle; literal checks pin the model.
module tb_branch_predict_nway;
  localparam int AW = 32;
  localparam int FW = 2;
  localparam int BD = 6;
  localparam int TW = 10;
  localparam int RD = 3;
  localparam int NB = 1 << BD;
  localparam int NR = 1 << RD;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  bit   started = 1'b0;
  always #5 clk = ~clk;

  branch_predict_nway_if #(.ADDR_WIDTH(AW), .LANE_WIDTH(1)) bp_if ();

  branch_predict_nway #(
    .ADDR_WIDTH(AW), .FETCH_WIDTH(FW), .BTB_DEPTH(BD),
    .TAG_WIDTH(TW), .RAS_DEPTH(RD), .GHR_WIDTH(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bp_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_vld [NB];
  int            m_tag [NB];
  logic [AW-1:0] m_tgt [NB];
  int            m_type[NB];
  int            m_ctr [NB];
  logic [AW-1:0] m_ras [NR];
  int            m_sp, m_sc, m_cp, m_cc;
  logic          e_vld;
  logic [AW-1:0] e_pc;
  logic          e_br;
  int            e_lane;

  function automatic int idx_of(input logic [AW-1:0] pc);
    return int'((pc >> 2) % NB);
  endfunction

  function automatic int tag_of(input logic [AW-1:0] pc);
    return int'((pc >> (BD + 2)) % (1 << TW));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_vld[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_type[i] = 0; m_ctr[i] = 1;
    end
    for (int i = 0; i < NR; i++) m_ras[i] = '0;
    m_sp = 0; m_sc = 0; m_cp = 0; m_cc = 0;
    e_vld = 1'b0; e_pc = '0; e_br = 1'b0; e_lane = 0;
  endtask

  task automatic model_step();
    logic [AW-1:0] lpc, wpc, tgt;
    int win, wtype, ix, tg, ety;
    win = -1; wpc = '0; wtype = 0; tgt = '0;
    // predict from the state as it stood before this edge
    for (int i = 0; i < FW; i++) begin
      lpc = bp_if.ifPC + AW'(4 * i);
      ix  = idx_of(lpc);
      tg  = tag_of(lpc);
      if (win < 0 && m_vld[ix] && m_tag[ix] == tg && (m_type[ix] != 0 || m_ctr[ix] >= 2)) begin
        win   = i;
        wpc   = lpc;
        wtype = m_type[ix];
        tgt   = (wtype == 3 && m_sc > 0) ? m_ras[(m_sp + NR - 1) % NR] : m_tgt[ix];
      end
    end
    e_vld = bp_if.ifVld && !bp_if.exWrong;
    if (e_vld) begin
      e_br   = (win >= 0);
      e_lane = (win >= 0) ? win : 0;
      e_pc   = (win >= 0) ? tgt : bp_if.ifPC + AW'(4 * FW);
      if (win >= 0 && wtype == 2) begin
        m_ras[m_sp] = wpc + 4;
        m_sp = (m_sp + 1) % NR;
        if (m_sc < NR) m_sc++;
      end else if (win >= 0 && wtype == 3 && m_sc > 0) begin
        m_sp = (m_sp + NR - 1) % NR;
        m_sc--;
      end
    end
    if (bp_if.exVld) begin
      ety = int'(bp_if.exType);
      if (ety == 2) begin
        m_ras[m_cp] = bp_if.exPC + 4;
        m_cp = (m_cp + 1) % NR;
        if (m_cc < NR) m_cc++;
      end else if (ety == 3 && m_cc > 0) begin
        m_cp = (m_cp + NR - 1) % NR;
        m_cc--;
      end
      ix = idx_of(bp_if.exPC);
      tg = tag_of(bp_if.exPC);
      if (m_vld[ix] && m_tag[ix] == tg) begin
        m_tgt[ix]  = bp_if.exPCTar;
        m_type[ix] = ety;
        m_ctr[ix]  = bp_if.exBranch ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                    : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
      end else if (bp_if.exBranch) begin
        m_vld[ix] = 1'b1; m_tag[ix] = tg; m_tgt[ix] = bp_if.exPCTar;
        m_type[ix] = ety; m_ctr[ix] = 2;
      end
    end
    if (bp_if.exWrong) begin
      m_sp = m_cp;
      m_sc = m_cc;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (started && !rst) begin
      check("model_pdVld",    AW'(bp_if.pdVld),    AW'(e_vld));
      check("model_pdPC",     bp_if.pdPC,          e_pc);
      check("model_pdBranch", AW'(bp_if.pdBranch), AW'(e_br));
      check("model_pdLane",   AW'(bp_if.pdLane),   AW'(e_lane));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bp_if.ifVld = 1'b0; bp_if.ifPC = '0;
    bp_if.exVld = 1'b0; bp_if.exPC = '0; bp_if.exPCTar = '0;
    bp_if.exType = 2'b00; bp_if.exBranch = 1'b0; bp_if.exWrong = 1'b0;
  endtask

  task automatic fetch(input logic [AW-1:0] pc);
    bp_if.ifVld = 1'b1; bp_if.ifPC = pc;
    @(negedge clk);
    bp_if.ifVld = 1'b0;
  endtask

  task automatic set_ex(input logic [AW-1:0] pc, input logic [AW-1:0] tar,
                        input logic [1:0] typ, input logic br);
    bp_if.exVld = 1'b1; bp_if.exPC = pc; bp_if.exPCTar = tar;
    bp_if.exType = typ; bp_if.exBranch = br;
  endtask

  task automatic train(input logic [AW-1:0] pc, input logic [AW-1:0] tar,
                       input logic [1:0] typ, input logic br);
    set_ex(pc, tar, typ, br);
    @(negedge clk);
    bp_if.exVld = 1'b0;
  endtask

  task automatic expect_pd(input string name, input logic vld, input logic br,
                           input int lane, input logic [AW-1:0] pc);
    check({name, "_vld"},    AW'(bp_if.pdVld),    AW'(vld));
    check({name, "_branch"}, AW'(bp_if.pdBranch), AW'(br));
    check({name, "_lane"},   AW'(bp_if.pdLane),   AW'(lane));
    check({name, "_pc"},     bp_if.pdPC,          pc);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    expect_pd("reset", 1'b0, 1'b0, 0, 32'h0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // sequential prediction out of an empty BTB
    fetch(32'h1000);
    expect_pd("seq", 1'b1, 1'b0, 0, 32'h1008);

    // conditional branch in lane 1, then trained down to not-taken
    train(32'h1004, 32'h2000, 2'b00, 1'b1);
    fetch(32'h1000);
    expect_pd("cond_taken", 1'b1, 1'b1, 1, 32'h2000);
    train(32'h1004, 32'h2000, 2'b00, 1'b0);
    train(32'h1004, 32'h2000, 2'b00, 1'b0);
    fetch(32'h1000);
    expect_pd("cond_nt", 1'b1, 1'b0, 0, 32'h1008);

    // call then return served from the RAS
    train(32'h1000, 32'h3000, 2'b10, 1'b1);
    train(32'h3010, 32'h7000, 2'b11, 1'b1);
    fetch(32'h1000);
    expect_pd("call", 1'b1, 1'b1, 0, 32'h3000);
    fetch(32'h3010);
    expect_pd("ret", 1'b1, 1'b1, 0, 32'h1004);

    // nine calls into an 8-deep RAS, committed side drained back to empty
    for (int k = 0; k < 9; k++) train(32'h5020 + 32'(8 * k), 32'h6000, 2'b10, 1'b1);
    repeat (8) train(32'h3010, 32'h7000, 2'b11, 1'b1);
    for (int k = 0; k < 9; k++) fetch(32'h5020 + 32'(8 * k));
    check("call9_pc", bp_if.pdPC, 32'h6000);
    for (int k = 1; k <= 9; k++) begin
      fetch(32'h3010);
      if (k == 1) check("ret_first", bp_if.pdPC, 32'h5064);
      if (k == 8) check("ret_eighth", bp_if.pdPC, 32'h502C);
      if (k == 9) check("ret_empty", bp_if.pdPC, 32'h7000);
    end

    // two speculative calls, then a flush while fetching
    fetch(32'h5020);
    fetch(32'h5028);
    bp_if.exWrong = 1'b1;
    fetch(32'h3010);
    bp_if.exWrong = 1'b0;
    check("flush_vld", AW'(bp_if.pdVld), AW'(1'b0));
    fetch(32'h3010);
    expect_pd("flush_ret", 1'b1, 1'b1, 0, 32'h7000);

    // allocation and lookup of index 5 in the same cycle
    set_ex(32'h8014, 32'h9000, 2'b01, 1'b1);
    fetch(32'h8014);
    bp_if.exVld = 1'b0;
    expect_pd("same_cyc", 1'b1, 1'b0, 0, 32'h801C);
    fetch(32'h8014);
    expect_pd("next_cyc", 1'b1, 1'b1, 0, 32'h9000);

    // fetch, committed call and flush all at once
    set_ex(32'h5030, 32'h6100, 2'b10, 1'b1);
    bp_if.exWrong = 1'b1;
    fetch(32'h5020);
    bp_if.exVld = 1'b0;
    bp_if.exWrong = 1'b0;
    check("triple_vld", AW'(bp_if.pdVld), AW'(1'b0));
    fetch(32'h3010);
    expect_pd("triple_ret", 1'b1, 1'b1, 0, 32'h5034);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
